// File: rtl/period_tag_tx_pkg.sv
// Shared types, defaults and helpers for the period tag serial transmitter.
package period_tag_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SYNC   = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_e;

    localparam logic [7:0]  SYNC_WORD_DEF  = 8'hD5;
    localparam int unsigned PERIOD_W_DEF   = 48;
    localparam int unsigned FRAME_OVERHEAD = 11;
    localparam int unsigned FRAME_BITS_DEF = PERIOD_W_DEF + FRAME_OVERHEAD;
    // Widest period the parity helper covers.
    localparam int unsigned PARITY_MAX_W   = 64;

    function automatic int unsigned frame_bits(input int unsigned period_w);
        return period_w + FRAME_OVERHEAD;
    endfunction

    // Even parity: XOR of all period bits; zero-extension leaves it unchanged.
    function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/period_tag_tx_if.sv
// Strobe/period inputs and serial/status outputs of the period tag transmitter.
interface period_tag_tx_if #(
    parameter int unsigned PERIOD_W = 48
);
    logic                en;
    logic                period_done;
    logic [PERIOD_W-1:0] period;
    logic                tx;
    logic                busy;
    logic                frame_sent;
    logic [7:0]          overrun_cnt;

    modport master (
        output en, period_done, period,
        input  tx, busy, frame_sent, overrun_cnt
    );

    modport slave (
        input  en, period_done, period,
        output tx, busy, frame_sent, overrun_cnt
    );
endinterface

// File: rtl/period_tag_tx_bit_tick.sv
// Bit-slot divider: counts 0..BIT_DIV-1, synchronous clear, registered tick on the last count.
module period_tag_tx_bit_tick #(
    parameter int unsigned BIT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    output logic       tick_o,
    output logic [7:0] cnt_o
);
    localparam logic [7:0] LAST = 8'(BIT_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + 8'd1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = 8'd0;
        end
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 8'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/period_tag_tx.sv
// Captures the period count on each accepted strobe and sends it as a framed,
// parity-protected word (start, sync, period MSB first, parity, stop) on tx.
module period_tag_tx
    import period_tag_tx_pkg::*;
#(
    parameter int unsigned PERIOD_W  = PERIOD_W_DEF,
    parameter int unsigned BIT_DIV   = 4,
    parameter logic [7:0]  SYNC_WORD = SYNC_WORD_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    period_tag_tx_if.slave tag_if
);
    localparam int unsigned BCW        = (PERIOD_W > 8) ? $clog2(PERIOD_W) : 3;
    localparam logic [BCW-1:0] SYNC_LAST = BCW'(7);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(PERIOD_W - 1);
    localparam logic [7:0] DIV_PENULT  = 8'(BIT_DIV - 2);

    state_e              state_q, state_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PERIOD_W-1:0] shift_q, shift_d;
    logic [7:0]          sync_q, sync_d;
    logic                parity_q, parity_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                frame_sent_q, frame_sent_d;
    logic [7:0]          ovr_q, ovr_d;
    logic                accept_c;
    logic                strobe_c;
    logic                tick;
    logic [7:0]          div_cnt;

    period_tag_tx_bit_tick #(.BIT_DIV(BIT_DIV)) u_bit_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept_c),
        .tick_o (tick),
        .cnt_o  (div_cnt)
    );

    // Next-state logic: tx_d is the value of the bit slot that starts on the next edge.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        sync_d       = sync_q;
        parity_d     = parity_q;
        tx_d         = tx_q;
        ovr_d        = ovr_q;
        strobe_c     = tag_if.period_done && tag_if.en;
        accept_c     = 1'b0;

        case (state_q)
            ST_IDLE: tx_d = 1'b1;
            ST_START: if (tick) begin
                state_d   = ST_SYNC;
                bit_cnt_d = '0;
                tx_d      = sync_q[7];
                sync_d    = {sync_q[6:0], 1'b0};
            end
            ST_SYNC: if (tick) begin
                if (bit_cnt_q == SYNC_LAST) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[PERIOD_W-1];
                    shift_d   = {shift_q[PERIOD_W-2:0], 1'b0};
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    tx_d      = sync_q[7];
                    sync_d    = {sync_q[6:0], 1'b0};
                end
            end
            ST_DATA: if (tick) begin
                if (bit_cnt_q == DATA_LAST) begin
                    state_d = ST_PARITY;
                    tx_d    = parity_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    tx_d      = shift_q[PERIOD_W-1];
                    shift_d   = {shift_q[PERIOD_W-2:0], 1'b0};
                end
            end
            ST_PARITY: if (tick) begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
            end
            ST_STOP: if (tick) begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // The last stop cycle accepts a strobe so back-to-back frames have no idle gap.
        accept_c = strobe_c && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick));
        if (accept_c) begin
            state_d   = ST_START;
            bit_cnt_d = '0;
            shift_d   = tag_if.period;
            sync_d    = SYNC_WORD;
            parity_d  = calc_parity(PARITY_MAX_W'(tag_if.period));
            tx_d      = 1'b0;
        end else if (strobe_c && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        busy_d       = (state_d != ST_IDLE);
        frame_sent_d = (state_q == ST_STOP) && (div_cnt == DIV_PENULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            sync_q       <= 8'd0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_sent_q <= 1'b0;
            ovr_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sync_q       <= sync_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_sent_q <= frame_sent_d;
            ovr_q        <= ovr_d;
        end
    end

    assign tag_if.tx          = tx_q;
    assign tag_if.busy        = busy_q;
    assign tag_if.frame_sent  = frame_sent_q;
    assign tag_if.overrun_cnt = ovr_q;

endmodule

// File: tb/tb_period_tag_tx.sv
// Self-checking bench for period_tag_tx: per-cycle frame comparison against a bit-index model.
module tb_period_tag_tx;
    localparam int unsigned PW         = 48;
    localparam int unsigned DIV        = 4;
    localparam int unsigned FRAME_BITS = PW + 11;
    localparam int unsigned FRAME_CYC  = FRAME_BITS * DIV;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    period_tag_tx_if #(.PERIOD_W(PW)) tag_if ();

    period_tag_tx #(
        .PERIOD_W  (PW),
        .BIT_DIV   (DIV),
        .SYNC_WORD (8'hD5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_if (tag_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
        $fatal(1, "watchdog");
    end

    // Expected line level for frame bit number idx (0 = start bit).
    function automatic logic exp_bit(input logic [PW-1:0] p, input int idx);
        logic [7:0] s;
        s = 8'hD5;
        if (idx == 0)                 return 1'b0;
        else if (idx <= 8)            return s[8-idx];
        else if (idx <= int'(PW) + 8) return p[int'(PW) + 8 - idx];
        else if (idx == int'(PW) + 9) return ^p;
        else                          return 1'b1;
    endfunction

    function automatic logic [PW-1:0] rand_period();
        return PW'({$urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tag_if.en = 1'b0;
        tag_if.period_done = 1'b0;
        tag_if.period = '0;
        #12;
        n_checks += 4;
        if (tag_if.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b exp 1", tag_if.tx); end
        if (tag_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", tag_if.busy); end
        if (tag_if.frame_sent !== 1'b0) begin n_fail++; $display("FAIL reset_fs got %b exp 0", tag_if.frame_sent); end
        if (tag_if.overrun_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovr got %0d exp 0", tag_if.overrun_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 2;
        if (tag_if.tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_tx got %b exp 1", tag_if.tx); end
        if (tag_if.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b exp 0", tag_if.busy); end
    endtask

    // One frame, optionally launched here, with an optional strobe injected at cycle inj_k
    // and en dropped at cycle en_off_k; cycle 0 is the first start-bit cycle.
    task automatic test_frame(input string name, input logic [PW-1:0] p, input bit do_strobe,
                              input int inj_k, input logic [PW-1:0] inj_p, input logic inj_en,
                              input int en_off_k, input bit idle_after, input logic [7:0] exp_ovr);
        int   last;
        logic exp_tx, exp_busy, exp_fs;
        last = idle_after ? int'(FRAME_CYC) : int'(FRAME_CYC) - 1;
        if (do_strobe) begin
            @(negedge clk);
            tag_if.en = 1'b1;
            tag_if.period = p;
            tag_if.period_done = 1'b1;
            @(posedge clk);
            #1;
            tag_if.period_done = 1'b0;
            tag_if.period = rand_period();
        end
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            exp_tx   = (k < int'(FRAME_CYC)) ? exp_bit(p, k / int'(DIV)) : 1'b1;
            exp_busy = (k < int'(FRAME_CYC));
            exp_fs   = (k == int'(FRAME_CYC) - 1);
            n_checks += 3;
            if (tag_if.tx !== exp_tx) begin
                n_fail++; $display("FAIL %s tx cycle %0d got %b exp %b", name, k, tag_if.tx, exp_tx);
            end
            if (tag_if.busy !== exp_busy) begin
                n_fail++; $display("FAIL %s busy cycle %0d got %b exp %b", name, k, tag_if.busy, exp_busy);
            end
            if (tag_if.frame_sent !== exp_fs) begin
                n_fail++; $display("FAIL %s frame_sent cycle %0d got %b exp %b", name, k, tag_if.frame_sent, exp_fs);
            end
            if (k == en_off_k) tag_if.en = 1'b0;
            tag_if.period_done = (k == inj_k);
            if (k == inj_k) begin
                tag_if.period = inj_p;
                tag_if.en = inj_en;
            end
        end
        n_checks++;
        if (tag_if.overrun_cnt !== exp_ovr) begin
            n_fail++; $display("FAIL %s overrun_cnt got %0d exp %0d", name, tag_if.overrun_cnt, exp_ovr);
        end
    endtask

    task automatic test_en_low();
        @(negedge clk);
        tag_if.en = 1'b0;
        tag_if.period = rand_period();
        tag_if.period_done = 1'b1;
        @(negedge clk);
        tag_if.period_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n_checks += 3;
            if (tag_if.tx !== 1'b1) begin n_fail++; $display("FAIL en_low tx cycle %0d got %b exp 1", k, tag_if.tx); end
            if (tag_if.busy !== 1'b0) begin n_fail++; $display("FAIL en_low busy cycle %0d got %b exp 0", k, tag_if.busy); end
            if (tag_if.overrun_cnt !== 8'd0) begin
                n_fail++; $display("FAIL en_low ovr cycle %0d got %0d exp 0", k, tag_if.overrun_cnt);
            end
        end
        test_frame("en_drop", rand_period(), 1'b1, 60, rand_period(), 1'b0, 50, 1'b1, 8'd0);
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] pa, pb;
        pa = rand_period();
        pb = rand_period();
        test_frame("b2b_first", pa, 1'b1, int'(FRAME_CYC) - 1, pb, 1'b1, -1, 1'b0, 8'd0);
        test_frame("b2b_second", pb, 1'b0, -1, '0, 1'b1, -1, 1'b1, 8'd0);
    endtask

    task automatic test_overrun();
        int next_free;
        int drops;
        int exp_ovr;
        test_frame("overrun_single", rand_period(), 1'b1, 100, rand_period(), 1'b1, -1, 1'b1, 8'd1);
        // Strobe i sits in cycle 10*i; a frame launched from cycle c leaves room for the
        // next one in cycle c+FRAME_CYC (its frame_sent cycle).
        next_free = 0;
        drops = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            tag_if.en = 1'b1;
            tag_if.period = rand_period();
            tag_if.period_done = 1'b1;
            if (i * 10 >= next_free) next_free = i * 10 + int'(FRAME_CYC);
            else drops++;
            @(negedge clk);
            tag_if.period_done = 1'b0;
            exp_ovr = (1 + drops > 255) ? 255 : 1 + drops;
            n_checks++;
            if (tag_if.overrun_cnt !== 8'(exp_ovr)) begin
                n_fail++; $display("FAIL overrun_sat strobe %0d got %0d exp %0d", i, tag_if.overrun_cnt, exp_ovr);
            end
            repeat (8) @(negedge clk);
        end
        for (int i = 0; i < int'(FRAME_CYC) + 10 && tag_if.busy; i++) @(negedge clk);
        n_checks++;
        if (tag_if.busy !== 1'b0) begin
            n_fail++; $display("FAIL overrun_drain busy got %b exp 0 within budget", tag_if.busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        tag_if.en = 1'b1;
        tag_if.period = rand_period();
        tag_if.period_done = 1'b1;
        @(posedge clk);
        #1;
        tag_if.period_done = 1'b0;
        for (int k = 0; k < 120; k++) @(negedge clk);
        n_checks++;
        if (tag_if.busy !== 1'b1) begin n_fail++; $display("FAIL mid_frame busy got %b exp 1", tag_if.busy); end
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (tag_if.tx !== 1'b1) begin n_fail++; $display("FAIL async_rst tx got %b exp 1", tag_if.tx); end
        if (tag_if.busy !== 1'b0) begin n_fail++; $display("FAIL async_rst busy got %b exp 0", tag_if.busy); end
        if (tag_if.frame_sent !== 1'b0) begin n_fail++; $display("FAIL async_rst fs got %b exp 0", tag_if.frame_sent); end
        if (tag_if.overrun_cnt !== 8'd0) begin
            n_fail++; $display("FAIL async_rst ovr got %0d exp 0", tag_if.overrun_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks += 2;
        if (tag_if.tx !== 1'b1) begin n_fail++; $display("FAIL rst_idle tx got %b exp 1", tag_if.tx); end
        if (tag_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle busy got %b exp 0", tag_if.busy); end
        test_frame("post_reset", rand_period(), 1'b1, -1, '0, 1'b1, -1, 1'b1, 8'd0);
    endtask

    initial begin
        test_reset();
        test_frame("one", 48'h000000000001, 1'b1, -1, '0, 1'b1, -1, 1'b1, 8'd0);
        test_frame("all_ones", 48'hFFFFFFFFFFFF, 1'b1, -1, '0, 1'b1, -1, 1'b1, 8'd0);
        for (int i = 0; i < 3; i++) begin
            test_frame("random", rand_period(), 1'b1, -1, '0, 1'b1, -1, 1'b1, 8'd0);
        end
        test_en_low();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
